clock_multiplier: RTL and testbench
===================================

CLOCK_MULTIPLIER -- requirements
Module: clock_multiplier

Interface
REQ-001 The module SHALL have parameter M, default 4: enable multiplication ratio (output pulses per input period), M >= 2.
REQ-002 The module SHALL have parameter W, default 16: period counter width in bits.
REQ-003 The module SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 The module SHALL have port en_i, input, 1: low-rate clock enable, single-cycle pulses with period P clocks.
REQ-006 The module SHALL have port en_o, output, 1: high-rate clock enable, M evenly spaced single-cycle pulses per input period.
REQ-007 The module SHALL have port locked, output, 1, present only with CLOCK_MULTIPLIER_STATUS_EN: state == LOCKED.
REQ-008 The module SHALL have port period_o, output, W, present only with CLOCK_MULTIPLIER_STATUS_EN: latched period P.

Function
REQ-009 The module SHALL implement states IDLE, MEASURE and LOCKED.
REQ-010 Period definition: P SHALL equal the number of clk cycles from one en_i pulse to the next, e.g. en_i every 4th cycle gives P=4.
REQ-011 Period counter cnt (W bits) SHALL clear on every en_i cycle, increment on every other cycle and saturate at 2^W-1.
REQ-012 IDLE -> MEASURE SHALL occur on en_i; en_o stays 0.
REQ-013 MEASURE -> LOCKED SHALL occur on en_i when M <= cnt+1 <= 2^W-1; P <= cnt+1.
REQ-014 MEASURE SHALL be retained on en_i with cnt+1 < M; counting restarts and no pulse is produced.
REQ-015 LOCKED on en_i with valid period (per REQ-013) SHALL stay LOCKED and set P <= cnt+1, so the period tracks changes every input pulse.
REQ-016 LOCKED on en_i with cnt+1 < M SHALL go to MEASURE; no pulse is produced.
REQ-017 Any state SHALL go to IDLE when cnt reaches 2^W-1 (input timeout); en_o stays 0 from that cycle.
REQ-018 en_o SHALL be registered, with one cycle latency: an en_i that enters or stays in LOCKED yields en_o=1 on the following cycle.
REQ-019 On that en_i cycle the generator SHALL set acc <= 0 and pulse count k <= 0.
REQ-020 Between input pulses, in LOCKED, each cycle the generator SHALL compute s = acc + M.
REQ-021 If s >= P and k < M-1, the generator SHALL emit en_o next cycle, set acc <= s - P and k <= k+1; otherwise acc <= s with no pulse.
REQ-022 acc and s SHALL be wide enough that s never overflows (W+$clog2(M)+1 bits); the comparison SHALL be unsigned.
REQ-023 Pulses SHALL never exceed M per input period; if en_i arrives early (P shrinks), remaining pulses SHALL be dropped and the generator resynced per REQ-019.
REQ-024 For P divisible by M, pulses SHALL be exactly P/M cycles apart. Otherwise spacing SHALL be floor or ceil of P/M.
REQ-025 en_o SHALL never be asserted in IDLE or MEASURE, except the single delayed pulse from the transition cycle per REQ-018.

Reset
REQ-026 On reset=1 at a clk edge, state SHALL be IDLE and cnt, P, acc, k and en_o SHALL be 0.
REQ-027 locked and period_o, when present, SHALL be 0 on reset.
REQ-028 Reset mid-operation SHALL abort generation immediately: no en_o pulse is produced in the cycle after reset is sampled.
REQ-029 en_i during reset SHALL be ignored.

Configuration
REQ-030 With macro CLOCK_MULTIPLIER_STATUS_EN defined, ports locked and period_o SHALL exist and be driven directly from registers.
REQ-031 Without CLOCK_MULTIPLIER_STATUS_EN, those ports and any logic only they use SHALL be absent; en_o behaviour SHALL be identical in both builds.

Verification
REQ-032 M=4, en_i every 8 cycles: 1st en_i -> no en_o; 2nd en_i at t -> en_o at t+1, t+3, t+5, t+7, repeating every 8 cycles; locked=1 after t.
REQ-033 M=2, en_i every 5 cycles: en_o at 1 and 4 cycles after each en_i (spacing 3,2); exactly 2 pulses per period.
REQ-034 M=4, locked at P=8, then one en_i after 5 cycles: pulses after 1 and 3 only; then resync, P=5, spacing from {1,2}.
REQ-035 M=4, locked, then en_i 2 cycles apart -> state MEASURE, en_o=0, locked=0; next valid period relocks.
REQ-036 W=8, locked, en_i stops -> state IDLE 255 cycles after the last en_i; en_o stays 0 thereafter.
REQ-037 Reset asserted one cycle between generated pulses -> en_o=0 next cycle, all outputs 0; relock requires two fresh en_i pulses.

Source files
------------

// File: rtl/clock_multiplier.sv
// clock_multiplier: turns a low-rate single-cycle enable en_i (period P clocks)
// into M evenly spaced single-cycle enables en_o per input period.
// Parameters: M (pulses per input period, >= 2), W (period counter width).
// Ports: clk, reset (sync, active-high), en_i (low-rate enable in),
//        en_o (high-rate enable out, registered, one cycle after the decision).
// Optional CLOCK_MULTIPLIER_STATUS_EN adds locked (generator locked) and
// period_o (last measured period P), both driven straight from registers.
module clock_multiplier #(
    parameter int M = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic         en_o
`ifdef CLOCK_MULTIPLIER_STATUS_EN
    ,
    output logic         locked,
    output logic [W-1:0] period_o
`endif
);
    localparam int AW = W + $clog2(M) + 1;
    localparam int KW = $clog2(M);
    localparam logic [W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    cnt, cnt_nxt, p, p_nxt;
    logic [AW-1:0]   acc, acc_nxt, s;
    logic [KW-1:0]   k, k_nxt;
    logic            en_nxt, valid, timeout, fire;

    always_comb begin
        cnt_nxt   = en_i ? '0 : (cnt == MAX ? cnt : cnt + 1'b1);
        valid     = (cnt != MAX) && ((AW'(cnt) + AW'(1)) >= AW'(M));
        // timeout takes effect on the edge where cnt saturates
        timeout   = !en_i && (cnt_nxt == MAX);
        s         = acc + AW'(M);
        // fractional accumulator: one pulse each time M/P worth of phase wraps;
        // the pulse launched by en_i itself is pulse 0, so at most M-1 more here
        fire      = (state == LOCKED) && !en_i && !timeout &&
                    (s >= AW'(p)) && (k < KW'(M - 1));
        state_nxt = state;
        p_nxt     = p;
        acc_nxt   = acc;
        k_nxt     = k;
        en_nxt    = 1'b0;
        if (en_i) begin
            acc_nxt = '0;
            k_nxt   = '0;
            if (state != IDLE && valid) begin
                state_nxt = LOCKED;
                p_nxt     = cnt + 1'b1;
                en_nxt    = 1'b1;
            end else begin
                state_nxt = MEASURE;
            end
        end else if (timeout) begin
            state_nxt = IDLE;
        end else if (state == LOCKED) begin
            acc_nxt = fire ? s - AW'(p) : s;
            k_nxt   = fire ? k + 1'b1 : k;
            en_nxt  = fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= '0;
            acc   <= '0;
            k     <= '0;
            en_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            p     <= p_nxt;
            acc   <= acc_nxt;
            k     <= k_nxt;
            en_o  <= en_nxt;
        end
    end

`ifdef CLOCK_MULTIPLIER_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
        end else begin
            locked <= (state_nxt == LOCKED);
        end
    end
    assign period_o = p;
`endif
endmodule

// File: tb/tb_clock_multiplier.sv
// tb_clock_multiplier: directed bench for clock_multiplier (M=4 and M=2, W=8).
module tb_clock_multiplier;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_i = 1'b0;
    logic       en4, en2;
    int         checks = 0;
    int         failures = 0;
    logic [31:0] v4, v2;
    int         n4, n2;
`ifdef CLOCK_MULTIPLIER_STATUS_EN
    logic       lk4, lk2;
    logic [7:0] per4, per2;
`endif

    always #5 clk = ~clk;

    clock_multiplier #(.M(4), .W(8)) dut4 (
        .clk(clk), .reset(reset), .en_i(en_i), .en_o(en4)
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        , .locked(lk4), .period_o(per4)
`endif
    );

    clock_multiplier #(.M(2), .W(8)) dut2 (
        .clk(clk), .reset(reset), .en_i(en_i), .en_o(en2)
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        , .locked(lk2), .period_o(per2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive en_i for one cycle, then land 1 time unit after the edge
    task automatic step(input logic e);
        en_i = e;
        @(posedge clk);
        #1;
    endtask

    // one input period of p cycles; bit j-1 holds en_o seen j cycles after en_i
    task automatic run(input int p, output logic [31:0] o4, output logic [31:0] o2);
        o4 = '0;
        o2 = '0;
        for (int j = 0; j < p; j++) begin
            step(j == 0);
            o4[j] = en4;
            o2[j] = en2;
        end
    endtask

    initial begin
        // reset with en_i held high: en_i must be ignored
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        check("rst_en4", 32'(en4), 32'd0);
        check("rst_en2", 32'(en2), 32'd0);
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        check("rst_lk4", 32'(lk4), 32'd0);
        check("rst_per4", 32'(per4), 32'd0);
`endif
        reset = 1'b0;
        step(1'b0);

        // first en_i only starts measuring
        run(8, v4, v2);
        check("p8_first_m4", v4, 32'h00);
        check("p8_first_m2", v2, 32'h00);
        // locked at P=8: M=4 pulses at +1,+3,+5,+7; M=2 at +1,+5
        run(8, v4, v2);
        check("p8_lock_m4", v4, 32'h55);
        check("p8_lock_m2", v2, 32'h11);
        run(8, v4, v2);
        check("p8_again_m4", v4, 32'h55);
        check("p8_again_m2", v2, 32'h11);
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        check("p8_lk4", 32'(lk4), 32'd1);
        check("p8_per4", 32'(per4), 32'd8);
`endif

        // early en_i after 5 cycles: only the +1 and +3 pulses before it
        run(5, v4, v2);
        check("early_m4", v4 & 32'hF, 32'h5);
        check("early_m2", v2 & 32'hF, 32'h1);
        // resynced at P=5: M=4 at +1,+3,+4,+5; M=2 at +1,+4
        run(5, v4, v2);
        check("p5_m4", v4, 32'h1D);
        check("p5_m2", v2, 32'h09);
        run(5, v4, v2);
        check("p5_again_m4", v4, 32'h1D);
        check("p5_again_m2", v2, 32'h09);
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        check("p5_per4", 32'(per4), 32'd5);
`endif

        // too-short period (2 cycles): M=4 drops to MEASURE, M=2 still valid
        run(2, v4, v2);
        check("short_lead_m4", v4, 32'h1);
        check("short_lead_m2", v2, 32'h1);
        run(8, v4, v2);
        check("short_m4", v4, 32'h00);
        check("short_m2", v2, 32'h03);
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        check("short_lk4", 32'(lk4), 32'd0);
        check("short_lk2", 32'(lk2), 32'd1);
`endif
        run(8, v4, v2);
        check("relock_m4", v4, 32'h55);
        check("relock_m2", v2, 32'h11);

        // reset between pulses +1 and +3 suppresses the +3 pulse
        step(1'b1);
        check("prerst_m4", 32'(en4), 32'd1);
        step(1'b0);
        reset = 1'b1;
        step(1'b0);
        check("midrst_m4", 32'(en4), 32'd0);
        check("midrst_m2", 32'(en2), 32'd0);
`ifdef CLOCK_MULTIPLIER_STATUS_EN
        check("midrst_lk4", 32'(lk4), 32'd0);
        check("midrst_per4", 32'(per4), 32'd0);
`endif
        reset = 1'b0;
        step(1'b0);
        run(8, v4, v2);
        check("rst_first_m4", v4, 32'h00);
        check("rst_first_m2", v2, 32'h00);
        run(8, v4, v2);
        check("rst_relock_m4", v4, 32'h55);
        check("rst_relock_m2", v2, 32'h11);

        // en_i stops: exactly one period's worth of pulses, then silence
        n4 = 0;
        n2 = 0;
        for (int j = 1; j <= 300; j++) begin
            step(j == 1);
            n4 += int'(en4);
            n2 += int'(en2);
`ifdef CLOCK_MULTIPLIER_STATUS_EN
            if (j == 250) check("to_lk4_before", 32'(lk4), 32'd1);
            if (j == 260) check("to_lk4_after", 32'(lk4), 32'd0);
`endif
        end
        check("timeout_cnt_m4", 32'(n4), 32'd4);
        check("timeout_cnt_m2", 32'(n2), 32'd2);
        check("timeout_idle_m4", 32'(en4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
